// File: rtl/prefix_adder_16.sv
// Sklansky parallel-prefix adder with a registered {Cout,S} stage.
// Carry-in enters the tree as prefix position 0, so bit i of A/B sits at position i+1.
module prefix_adder_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int unsigned LEVELS = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_g_base;
  logic [WIDTH:0]   w_p_base;
  logic [WIDTH:0]   w_g_final;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_unused_p;

  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  assign w_g      = A & B;
  assign w_p      = A ^ B;
  assign w_g_base = {w_g, Cin};
  assign w_p_base = {w_p, 1'b0};

  genvar k, j;
  for (k = 0; k < LEVELS; k++) begin : g_lvl
    logic [WIDTH:0] w_gi;
    logic [WIDTH:0] w_pi;
    logic [WIDTH:0] w_go;
    logic [WIDTH:0] w_po;

    if (k == 0) begin : g_src
      assign w_gi = w_g_base;
      assign w_pi = w_p_base;
    end else begin : g_src
      assign w_gi = g_lvl[k-1].w_go;
      assign w_pi = g_lvl[k-1].w_po;
    end

    for (j = 0; j <= WIDTH; j++) begin : g_node
      if (((j >> k) & 1) == 1) begin : g_op
        // Upper half of a 2^(k+1) block takes the top of the lower half.
        localparam int unsigned Lo = ((j >> k) << k) - 1;
        assign w_go[j] = w_gi[j] | (w_pi[j] & w_gi[Lo]);
        assign w_po[j] = w_pi[j] & w_pi[Lo];
      end else begin : g_pass
        assign w_go[j] = w_gi[j];
        assign w_po[j] = w_pi[j];
      end
    end
  end

  assign w_g_final  = g_lvl[LEVELS-1].w_go;
  assign w_unused_p = ^g_lvl[LEVELS-1].w_po;

  // w_g_final[i] is the group generate of bit i-1 down to the carry-in.
  assign w_sum  = w_p ^ w_g_final[WIDTH-1:0];
  assign w_cout = w_g_final[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_cout;
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;

endmodule

// File: tb/tb_prefix_adder_16.sv
// Directed and randomised checks of prefix_adder_16 at WIDTH 16, 8 and 32.
module tb_prefix_adder_16;

  logic        clk;
  logic        reset;
  logic [15:0] a16, b16, s16;
  logic        cin16, co16;
  logic [7:0]  a8, b8, s8;
  logic        cin8, co8;
  logic [31:0] a32, b32, s32;
  logic        cin32, co32;

  int checks = 0;
  int errors = 0;
  logic [16:0] prev16;

  prefix_adder_16 #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .Cin(cin16), .S(s16), .Cout(co16)
  );
  prefix_adder_16 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .A(a8), .B(b8), .Cin(cin8), .S(s8), .Cout(co8)
  );
  prefix_adder_16 #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .A(a32), .B(b32), .Cin(cin32), .S(s32), .Cout(co32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, confirm the old result still holds, then check after the edge.
  task automatic step16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [16:0] exp);
    @(negedge clk);
    a16   = a;
    b16   = b;
    cin16 = c;
    #1 chk({tag, "_hold"}, {47'd0, co16, s16}, {47'd0, prev16});
    @(posedge clk);
    #1 chk(tag, {47'd0, co16, s16}, {47'd0, exp});
    prev16 = exp;
  endtask

  initial begin
    logic [63:0] exp;
    reset = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    a8  = '0; b8  = '0; cin8  = 1'b0;
    a32 = '0; b32 = '0; cin32 = 1'b0;
    prev16 = '0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst16", {47'd0, co16, s16}, 64'd0);
    chk("rst8", {55'd0, co8, s8}, 64'd0);
    chk("rst32", {31'd0, co32, s32}, 64'd0);

    @(negedge clk);
    a16 = 16'd5; b16 = 16'd7;
    @(posedge clk);
    #1 chk("rst_hold", {47'd0, co16, s16}, 64'd0);

    @(negedge clk);
    reset = 1'b0;
    a16 = 16'd1; b16 = 16'd1; cin16 = 1'b0;
    #1 chk("rel_hold", {47'd0, co16, s16}, 64'd0);
    @(posedge clk);
    #1 chk("one_one", {47'd0, co16, s16}, 64'd2);
    prev16 = 17'd2;

    step16("one_one_c", 16'd1, 16'd1, 1'b1, 17'd3);
    step16("mid_412", 16'd412, 16'd33, 1'b0, 17'd445);
    step16("mid_623", 16'd623, 16'd0, 1'b0, 17'd623);
    step16("mid_3231", 16'd3, 16'd3231, 1'b0, 17'd3234);

    // Input change mid-cycle must not reach the registered outputs.
    #2;
    a16 = 16'hffff; b16 = 16'hffff; cin16 = 1'b1;
    #1 chk("midcycle", {47'd0, co16, s16}, 64'd3234);

    step16("wrap0", 16'd0, 16'hffff, 1'b0, 17'h0ffff);
    step16("wrap1", 16'd1, 16'hffff, 1'b0, 17'h10000);
    step16("wrap2", 16'd2, 16'hffff, 1'b0, 17'h10001);
    step16("allones_c", 16'hffff, 16'hffff, 1'b1, 17'h1ffff);
    step16("cin_only", 16'd0, 16'd0, 1'b1, 17'd1);

    step16("r1000", 16'd1000, 16'd2000, 1'b0, 17'd3000);
    #2 reset = 1'b1;
    #1 chk("rst_mid", {47'd0, co16, s16}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_mid_rel", {47'd0, co16, s16}, 64'd0);
    @(posedge clk);
    #1 chk("rst_mid_after", {47'd0, co16, s16}, 64'd3000);

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
      a32 = $urandom;      b32 = $urandom;      cin32 = 1'($urandom);
      @(posedge clk);
      #1;
      exp = 64'(a16) + 64'(b16) + 64'(cin16);
      chk("rand16", {47'd0, co16, s16}, exp);
      exp = 64'(a8) + 64'(b8) + 64'(cin8);
      chk("rand8", {55'd0, co8, s8}, exp);
      exp = 64'(a32) + 64'(b32) + 64'(cin32);
      chk("rand32", {31'd0, co32, s32}, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
